// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline encodings for the mul/div unit and its decoder.
package pipeline_pkg;
    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_ZDIV} md_state_e;
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one shift-add or restoring-subtract step per cycle on a shared 33-bit adder.
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iLoad,
    input  logic               iStep,
    input  logic               iDiv,
    input  logic [WIDTH-1:0]   iMagA,
    input  logic [WIDTH-1:0]   iMagB,
    output logic [2*WIDTH-1:0] oAcc
);
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic [WIDTH:0]     x, y, sum;
    logic               ge;
    // divide keeps {remainder, dividend/quotient}; multiply keeps {partial, multiplier}
    always_comb begin
        x      = div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        y      = div_q ? ~{1'b0, opnd_q} : ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
        sum    = x + y + {{WIDTH{1'b0}}, div_q};
        ge     = x[WIDTH] | ~sum[WIDTH];
        acc_d  = acc_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        if (iLoad) begin
            acc_d  = {{WIDTH{1'b0}}, iDiv ? iMagA : iMagB};
            opnd_d = iDiv ? iMagB : iMagA;
            div_d  = iDiv;
        end else if (iStep) begin
            acc_d = div_q ? {ge ? sum[WIDTH-1:0] : x[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
                          : {sum, acc_q[WIDTH-1:1]};
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
        end
    end
    assign oAcc = acc_q;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO and flush.
module ex_muldiv_unit
    import pipeline_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iOperandA,
    input  logic [WIDTH-1:0] iOperandB,
    input  logic             iHiWrite,
    input  logic             iLoWrite,
    input  logic [WIDTH-1:0] iWriteData,
    input  logic             iFlush,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo
);
    localparam int CW = $clog2(WIDTH);
    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d, sgna_q, sgna_d;
    logic [WIDTH-1:0]   a_q, a_d, hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               start, step, fix, zdiv, mt, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] acc, prod;

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .iLoad (start),
        .iStep (step),
        .iDiv  (md_is_div(iOp)),
        .iMagA (mag_a),
        .iMagB (mag_b),
        .oAcc  (acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= MD_IDLE;
        else        state_q <= state_d;
    end

    // a flush beats everything, including a same-cycle start in IDLE
    always_comb begin
        state_d = state_q;
        if (iFlush) state_d = MD_IDLE;
        else case (state_q)
            MD_IDLE: if (iStart) state_d = (md_is_div(iOp) && iOperandB == '0) ? MD_ZDIV : MD_CALC;
            MD_CALC: if (cnt_q == CW'(WIDTH-1)) state_d = MD_FIX;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        sa     = ~iOp[0] & iOperandA[WIDTH-1];
        sb     = ~iOp[0] & iOperandB[WIDTH-1];
        mag_a  = sa ? -iOperandA : iOperandA;
        mag_b  = sb ? -iOperandB : iOperandB;
        start  = state_q == MD_IDLE && iStart && !iFlush;
        step   = state_q == MD_CALC && !iFlush;
        fix    = state_q == MD_FIX && !iFlush;
        zdiv   = state_q == MD_ZDIV && !iFlush;
        mt     = state_q == MD_IDLE && !iStart;
        cnt_d  = start ? '0 : step ? cnt_q + 1'b1 : cnt_q;
        op_d   = start ? iOp : op_q;
        neg_d  = start ? sa ^ sb : neg_q;
        sgna_d = start ? sa : sgna_q;
        a_d    = start ? iOperandA : a_q;
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = sgna_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi_d   = fix ? (md_is_div(op_q) ? rem : prod[2*WIDTH-1:WIDTH])
               : zdiv ? a_q : (mt && iHiWrite) ? iWriteData : hi_q;
        lo_d   = fix ? (md_is_div(op_q) ? quo : prod[WIDTH-1:0])
               : zdiv ? '1 : (mt && iLoWrite) ? iWriteData : lo_q;
        busy_d = state_d != MD_IDLE;
        done_d = fix | zdiv;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            op_q   <= MD_OP_MULT;
            neg_q  <= 1'b0;
            sgna_q <= 1'b0;
            a_q    <= '0;
            hi_q   <= HILO_RESET;
            lo_q   <= HILO_RESET;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            sgna_q <= sgna_d;
            a_q    <= a_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oHi   = hi_q;
    assign oLo   = lo_q;
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded MULT/MULTU/DIV/DIVU operation and both register operands, and owns the architectural HI/LO registers.
- Accepts MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Raises oBusy so the hazard unit can stall IF/ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; only 32 is supported and verified. Iteration count equals WIDTH.
- HILO_RESET, 32'h00000000, reset value of HI and LO.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-low.
- iStart  input  1  launch operation; single-cycle pulse from EX when the ID/EX instruction is a mul/div.
- iOp  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- iOperandA  input  WIDTH  rs value after forwarding (multiplicand / dividend).
- iOperandB  input  WIDTH  rt value after forwarding (multiplier / divisor).
- iHiWrite  input  1  MTHI strobe.
- iLoWrite  input  1  MTLO strobe.
- iWriteData  input  WIDTH  MTHI/MTLO data.
- iFlush  input  1  abort in-flight operation (exception/redirect).
- oBusy  output  1  operation in flight; registered.
- oDone  output  1  one-cycle pulse; HI/LO were updated at the preceding edge.
- oHi  output  WIDTH  current HI register.
- oLo  output  WIDTH  current LO register.

Behaviour:
- Reset (async, reset=0): state=IDLE; oHi=oLo=HILO_RESET; oBusy=0; oDone=0; counter=0; internal accumulators=0.
- States:
  - IDLE: iStart=1 latches operands, magnitudes, sign flags and op. Goes to CALC with count=0, or to ZDIV if op is DIV/DIVU and B=0.
  - CALC: one iteration per edge. After the edge with count=WIDTH-1, goes to FIX.
  - FIX: applies sign correction, writes HI/LO, sets oDone=1 for one cycle, goes to IDLE.
  - ZDIV: writes LO=32'hFFFFFFFF and HI=iOperandA as latched, sets oDone=1, goes to IDLE.
- Latency: iStart sampled at edge E0. HI/LO and oDone are updated at edge E0+WIDTH+1 (33 for WIDTH=32). oBusy=1 in the cycles following E0 through E0+WIDTH; it is 0 in the cycle in which oDone=1. Divide-by-zero: result at E0+1, oBusy=1 for one cycle.
- Multiply: unsigned shift-add on magnitudes with a WIDTH+1-bit adder and a 2*WIDTH product register.
  - MULT negates the 64-bit product if sign(A)^sign(B).
  - {HI,LO} = product.
- Divide: restoring division on magnitudes.
  - Quotient is negated if sign(A)^sign(B).
  - Remainder takes sign(A).
  - LO=quotient, HI=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Unsigned ops (MULTU/DIVU) skip the magnitude and sign steps.
- MTHI/MTLO: in IDLE with iStart=0, the strobed register takes iWriteData at the edge. iHiWrite and iLoWrite may both be set in the same cycle.
- Simultaneous events:
  - iStart together with iHiWrite/iLoWrite in IDLE: start wins, writes are dropped.
  - iStart or MT* strobes while oBusy=1: ignored. The hazard unit guarantees this never happens; the bench flags it as an assertion.
  - iFlush in CALC/FIX/ZDIV: goes to IDLE at that edge, HI/LO unchanged, no oDone, oBusy=0 next cycle.
  - iFlush in IDLE overrides a same-cycle iStart (operation not launched).
- Reset asserted mid-operation: immediate abort to the reset values above.
- oHi/oLo update only at the FIX/ZDIV edge, MT* writes, or reset. Intermediate values are never visible.

Decomposition:
- Shared package pipeline_pkg:
  - MD_OP_MULT/MULTU/DIV/DIVU encodings.
  - funct constants 0x18–0x1B, 0x11 (MTHI), 0x13 (MTLO), 0x10 (MFHI), 0x12 (MFLO).
  - State encodings IDLE/CALC/FIX/ZDIV.
- One natural sub-module: md_iter_core. It holds the per-iteration datapath: shift-add step / restore-subtract step, 33-bit adder, and accumulator registers. The top holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULT A=-3 (0xFFFFFFFD), B=7 → at E0+33: HI=0xFFFFFFFF, LO=0xFFFFFFEB; oDone pulse 1 cycle; oBusy high exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100, B=7 → LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 → at E0+1: LO=0xFFFFFFFF, HI=0x1234, oDone=1; oBusy high 1 cycle.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F in IDLE → oHi/oLo match next cycle. Start MULT 5×5, then iFlush at E0+10 → no oDone, HI/LO keep 0xAAAA5555/0x0F0F0F0F, oBusy=0 next cycle.
- Reset deasserted → assert at E0+20 of a DIV → oHi=oLo=0, oBusy=0, oDone=0 immediately. Release and rerun DIVU 9/3 → LO=3, HI=0.
